// File: rtl/i2c_scl_engine_if.sv
// Command/strobe bundle between the I2C SCL engine and its command source / SDA block.
interface i2c_scl_engine_if;
   logic       Cmd_Valid;
   logic [1:0] Cmd;
   logic       Cmd_Ready;
   logic       Scl_Oe;
   logic       Scl_In;
   logic       Sda_Update;
   logic       Sda_Sample;
   logic       Start_Strobe;
   logic       Stop_Strobe;
   logic [3:0] Bit_Index;
   logic       Done;
   logic       Cmd_Err;
   logic       Timeout;

   modport master (
      output Cmd_Valid, Cmd, Scl_In,
      input  Cmd_Ready, Scl_Oe, Sda_Update, Sda_Sample, Start_Strobe, Stop_Strobe,
             Bit_Index, Done, Cmd_Err, Timeout
   );

   modport slave (
      input  Cmd_Valid, Cmd, Scl_In,
      output Cmd_Ready, Scl_Oe, Sda_Update, Sda_Sample, Start_Strobe, Stop_Strobe,
             Bit_Index, Done, Cmd_Err, Timeout
   );
endinterface

// File: rtl/i2c_scl_engine.sv
// Command-driven I2C SCL generator with SDA phase strobes.
// Optional clock stretching with timeout when SCL_STRETCH_EN is defined.
module i2c_scl_engine #(
   parameter int HALF_PERIOD     = 20,
   parameter int BITS_PER_FRAME  = 9,
   parameter int STRETCH_TIMEOUT = 1000
) (
   input logic             clk,
   input logic             rst,
   i2c_scl_engine_if.slave bus
);
   localparam int               CNT_W    = $clog2(HALF_PERIOD);
   localparam logic [CNT_W-1:0] MID      = CNT_W'(HALF_PERIOD / 2);
   localparam logic [CNT_W-1:0] LAST     = CNT_W'(HALF_PERIOD - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [3:0]       LAST_BIT = 4'(BITS_PER_FRAME - 1);

   localparam logic [1:0] CMD_START = 2'b00;
   localparam logic [1:0] CMD_FRAME = 2'b01;
   localparam logic [1:0] CMD_STOP  = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE, S_HOLD, S_RS_LOW, S_ST_HIGH, S_F_LOW, S_F_HIGH, S_P_LOW, S_P_HIGH
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       bit_q, bit_d;
   logic             scl_oe_q, scl_oe_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             timeout_q, timeout_d;

   logic accept;
   logic busy;
   logic high_half;
   logic hold_cnt;
   logic stretch_expired;
   logic half_end;
   logic at_mid;

   assign accept    = bus.Cmd_Valid && bus.Cmd_Ready;
   assign busy      = (state_q != S_IDLE) && (state_q != S_HOLD);
   assign high_half = (state_q == S_ST_HIGH) || (state_q == S_F_HIGH) || (state_q == S_P_HIGH);

`ifdef SCL_STRETCH_EN
   localparam int ST_W = $clog2(STRETCH_TIMEOUT + 1);

   logic            scl_in_p0, scl_in_p1;
   logic [ST_W-1:0] str_q, str_d;

   // Two-flop synchroniser for the asynchronous SCL pin readback
   always_ff @(posedge clk) begin
      scl_in_p0 <= bus.Scl_In;
      scl_in_p1 <= scl_in_p0;
   end

   // A high half does not start counting until the line is actually seen high
   assign hold_cnt        = high_half && (cnt_q == '0) && !scl_in_p1;
   assign stretch_expired = hold_cnt && (str_q == ST_W'(STRETCH_TIMEOUT - 1));

   always_comb begin
      str_d = '0;
      if (hold_cnt) str_d = str_q + ST_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) str_q <= '0;
      else     str_q <= str_d;
   end
`else
   localparam int unused_stretch_timeout = STRETCH_TIMEOUT;
   logic unused_scl_in;

   assign unused_scl_in   = bus.Scl_In;
   assign hold_cnt        = 1'b0;
   assign stretch_expired = 1'b0;
`endif

   assign half_end = !hold_cnt && (cnt_q == LAST);
   assign at_mid   = (cnt_q == MID);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      scl_oe_d  = scl_oe_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      timeout_d = 1'b0;

      if (busy && !hold_cnt) cnt_d = half_end ? '0 : cnt_q + CNT_ONE;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               cnt_d = '0;
               if (bus.Cmd == CMD_START) state_d = S_ST_HIGH;
               else                      err_d   = 1'b1;
            end
         end
         S_HOLD: begin
            if (accept) begin
               cnt_d = '0;
               case (bus.Cmd)
                  CMD_START: state_d = S_RS_LOW;
                  CMD_FRAME: state_d = S_F_LOW;
                  CMD_STOP:  state_d = S_P_LOW;
                  default:   err_d   = 1'b1;
               endcase
            end
         end
         S_RS_LOW: begin
            if (half_end) begin
               state_d  = S_ST_HIGH;
               scl_oe_d = 1'b0;
            end
         end
         S_ST_HIGH: begin
            if (half_end) begin
               state_d  = S_HOLD;
               scl_oe_d = 1'b1;
               done_d   = 1'b1;
            end
         end
         S_F_LOW: begin
            if (half_end) begin
               state_d  = S_F_HIGH;
               scl_oe_d = 1'b0;
            end
         end
         S_F_HIGH: begin
            if (half_end) begin
               scl_oe_d = 1'b1;
               if (bit_q == LAST_BIT) begin
                  state_d = S_HOLD;
                  bit_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_F_LOW;
                  bit_d   = bit_q + 4'd1;
               end
            end
         end
         S_P_LOW: begin
            if (half_end) begin
               state_d  = S_P_HIGH;
               scl_oe_d = 1'b0;
            end
         end
         S_P_HIGH: begin
            if (half_end) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A slave that never releases SCL forfeits the transfer
      if (stretch_expired) begin
         state_d   = S_IDLE;
         cnt_d     = '0;
         bit_d     = '0;
         scl_oe_d  = 1'b0;
         done_d    = 1'b0;
         timeout_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         scl_oe_q  <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         scl_oe_q  <= scl_oe_d;
         done_q    <= done_d;
         err_q     <= err_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.Cmd_Ready    = !rst && !busy;
   assign bus.Scl_Oe       = scl_oe_q;
   assign bus.Sda_Update   = at_mid && ((state_q == S_RS_LOW) || (state_q == S_F_LOW) ||
                                        (state_q == S_P_LOW));
   assign bus.Sda_Sample   = at_mid && (state_q == S_F_HIGH);
   assign bus.Start_Strobe = at_mid && (state_q == S_ST_HIGH);
   assign bus.Stop_Strobe  = at_mid && (state_q == S_P_HIGH);
   assign bus.Bit_Index    = bit_q;
   assign bus.Done         = done_q;
   assign bus.Cmd_Err      = err_q;
   assign bus.Timeout      = timeout_q;
endmodule

// File: tb/tb_i2c_scl_engine.sv
// Directed bench for i2c_scl_engine (HALF_PERIOD=20, BITS_PER_FRAME=9).
// Cycle c below is the c-th falling edge after the command-accepting rising edge (c=0 first).
module tb_i2c_scl_engine;
   localparam int HP  = 20;
   localparam int BPF = 9;

   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   i2c_scl_engine_if bus ();

   i2c_scl_engine #(.HALF_PERIOD(HP), .BITS_PER_FRAME(BPF), .STRETCH_TIMEOUT(1000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

`ifdef SCL_STRETCH_EN
   i2c_scl_engine_if bus2 ();

   i2c_scl_engine #(.HALF_PERIOD(HP), .BITS_PER_FRAME(BPF), .STRETCH_TIMEOUT(30)) dut_to (
      .clk (clk),
      .rst (rst),
      .bus (bus2.slave)
   );
`endif

   always #5 clk = ~clk;

   logic       scl_hist [0:1023];
   logic       rdy_hist [0:1023];
   logic [3:0] idx_smp  [0:15];
   int n_upd, n_smp, n_start, n_stop, n_done, n_err, n_to, n_multi;
   int first_upd, last_upd, first_smp, last_smp, first_start, first_stop, first_done, first_err;

   task automatic issue(input logic [1:0] c);
      bus.Cmd_Valid = 1'b1;
      bus.Cmd       = c;
      @(posedge clk);
      #1;
      bus.Cmd_Valid = 1'b0;
   endtask

   task automatic observe(input int n);
      int s;
      n_upd = 0; n_smp = 0; n_start = 0; n_stop = 0; n_done = 0; n_err = 0; n_to = 0; n_multi = 0;
      first_upd = -1; last_upd = -1; first_smp = -1; last_smp = -1;
      first_start = -1; first_stop = -1; first_done = -1; first_err = -1;
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         scl_hist[c] = bus.Scl_Oe;
         rdy_hist[c] = bus.Cmd_Ready;
         if (bus.Sda_Update) begin
            if (n_upd == 0) first_upd = c;
            last_upd = c;
            n_upd++;
         end
         if (bus.Sda_Sample) begin
            if (n_smp < 16) idx_smp[n_smp] = bus.Bit_Index;
            if (n_smp == 0) first_smp = c;
            last_smp = c;
            n_smp++;
         end
         if (bus.Start_Strobe) begin if (n_start == 0) first_start = c; n_start++; end
         if (bus.Stop_Strobe)  begin if (n_stop == 0)  first_stop  = c; n_stop++;  end
         if (bus.Done)         begin if (n_done == 0)  first_done  = c; n_done++;  end
         if (bus.Cmd_Err)      begin if (n_err == 0)   first_err   = c; n_err++;   end
         if (bus.Timeout) n_to++;
         s = int'(bus.Sda_Update) + int'(bus.Sda_Sample) + int'(bus.Start_Strobe) +
             int'(bus.Stop_Strobe);
         if (s > 1 || (bus.Done && bus.Cmd_Err)) n_multi++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bus.Cmd_Valid = 1'b0;
      bus.Cmd = 2'b00;
      bus.Scl_In = 1'b1;
`ifdef SCL_STRETCH_EN
      bus2.Cmd_Valid = 1'b0;
      bus2.Cmd = 2'b00;
      bus2.Scl_In = 1'b1;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (bus.Cmd_Ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b expected 0", bus.Cmd_Ready); end
      n_tests++;
      if (bus.Scl_Oe !== 1'b0) begin n_fail++; $display("FAIL rst_scl_oe: got %b expected 0", bus.Scl_Oe); end
      n_tests++;
      if (bus.Bit_Index !== 4'd0) begin n_fail++; $display("FAIL rst_bit_index: got %0d expected 0", bus.Bit_Index); end
      n_tests++;
      if ({bus.Sda_Update, bus.Sda_Sample, bus.Start_Strobe, bus.Stop_Strobe, bus.Done, bus.Cmd_Err, bus.Timeout} !== 7'd0) begin
         n_fail++;
         $display("FAIL rst_pulses: got %b expected 0000000",
                  {bus.Sda_Update, bus.Sda_Sample, bus.Start_Strobe, bus.Stop_Strobe, bus.Done, bus.Cmd_Err, bus.Timeout});
      end
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_tests++;
      if (bus.Cmd_Ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %b expected 1", bus.Cmd_Ready); end
   endtask

   task automatic test_start;
      issue(2'b00);
      observe(21);
      n_tests++;
      if (rdy_hist[0] !== 1'b0) begin n_fail++; $display("FAIL start_ready_drop: got %b expected 0", rdy_hist[0]); end
      n_tests++;
      if (first_start !== 10 || n_start !== 1) begin n_fail++; $display("FAIL start_strobe: cycle %0d count %0d expected cycle 10 count 1", first_start, n_start); end
      n_tests++;
      if (scl_hist[10] !== 1'b0 || scl_hist[19] !== 1'b0) begin n_fail++; $display("FAIL start_scl_high: got %b%b expected 00", scl_hist[10], scl_hist[19]); end
      n_tests++;
      if (scl_hist[20] !== 1'b1) begin n_fail++; $display("FAIL start_scl_low_at_20: got %b expected 1", scl_hist[20]); end
      n_tests++;
      if (first_done !== 20 || n_done !== 1) begin n_fail++; $display("FAIL start_done: cycle %0d count %0d expected cycle 20 count 1", first_done, n_done); end
      n_tests++;
      if (rdy_hist[20] !== 1'b1) begin n_fail++; $display("FAIL start_hold_ready: got %b expected 1", rdy_hist[20]); end
      n_tests++;
      if (n_upd !== 0 || n_multi !== 0) begin n_fail++; $display("FAIL start_extra_strobes: upd %0d multi %0d expected 0 0", n_upd, n_multi); end
   endtask

   task automatic test_frame;
      issue(2'b01);
      observe(361);
      n_tests++;
      if (n_upd !== BPF || n_smp !== BPF) begin n_fail++; $display("FAIL frame_counts: upd %0d smp %0d expected 9 9", n_upd, n_smp); end
      n_tests++;
      if (first_upd !== 10 || last_upd !== 330) begin n_fail++; $display("FAIL frame_upd_times: first %0d last %0d expected 10 330", first_upd, last_upd); end
      n_tests++;
      if (first_smp !== 30 || last_smp !== 350) begin n_fail++; $display("FAIL frame_smp_times: first %0d last %0d expected 30 350", first_smp, last_smp); end
      for (int k = 0; k < BPF; k++) begin
         n_tests++;
         if (idx_smp[k] !== 4'(k)) begin n_fail++; $display("FAIL frame_bit_index[%0d]: got %0d expected %0d", k, idx_smp[k], k); end
      end
      n_tests++;
      if (scl_hist[19] !== 1'b1 || scl_hist[20] !== 1'b0 || scl_hist[359] !== 1'b0 || scl_hist[360] !== 1'b1) begin
         n_fail++;
         $display("FAIL frame_scl_edges: got %b%b%b%b expected 1001", scl_hist[19], scl_hist[20], scl_hist[359], scl_hist[360]);
      end
      n_tests++;
      if (first_done !== 360 || n_done !== 1) begin n_fail++; $display("FAIL frame_done: cycle %0d count %0d expected cycle 360 count 1", first_done, n_done); end
      n_tests++;
      if (bus.Bit_Index !== 4'd0 || bus.Cmd_Ready !== 1'b1) begin n_fail++; $display("FAIL frame_end_hold: idx %0d ready %b expected 0 1", bus.Bit_Index, bus.Cmd_Ready); end
      n_tests++;
      if (n_start !== 0 || n_stop !== 0 || n_multi !== 0 || n_to !== 0) begin
         n_fail++;
         $display("FAIL frame_extra: start %0d stop %0d multi %0d timeout %0d expected all 0", n_start, n_stop, n_multi, n_to);
      end
   endtask

   task automatic test_rs_stop;
      issue(2'b00);
      observe(41);
      n_tests++;
      if (first_upd !== 10 || n_upd !== 1) begin n_fail++; $display("FAIL rs_upd: cycle %0d count %0d expected cycle 10 count 1", first_upd, n_upd); end
      n_tests++;
      if (first_start !== 30 || n_start !== 1) begin n_fail++; $display("FAIL rs_start: cycle %0d count %0d expected cycle 30 count 1", first_start, n_start); end
      n_tests++;
      if (scl_hist[19] !== 1'b1 || scl_hist[20] !== 1'b0 || scl_hist[40] !== 1'b1) begin
         n_fail++;
         $display("FAIL rs_scl: got %b%b%b expected 101", scl_hist[19], scl_hist[20], scl_hist[40]);
      end
      n_tests++;
      if (first_done !== 40 || n_done !== 1) begin n_fail++; $display("FAIL rs_done: cycle %0d count %0d expected cycle 40 count 1", first_done, n_done); end
      issue(2'b10);
      observe(41);
      n_tests++;
      if (first_upd !== 10 || n_upd !== 1) begin n_fail++; $display("FAIL stop_upd: cycle %0d count %0d expected cycle 10 count 1", first_upd, n_upd); end
      n_tests++;
      if (first_stop !== 30 || n_stop !== 1) begin n_fail++; $display("FAIL stop_strobe: cycle %0d count %0d expected cycle 30 count 1", first_stop, n_stop); end
      n_tests++;
      if (scl_hist[19] !== 1'b1 || scl_hist[30] !== 1'b0) begin n_fail++; $display("FAIL stop_scl: got %b%b expected 10", scl_hist[19], scl_hist[30]); end
      n_tests++;
      if (first_done !== 40 || n_done !== 1) begin n_fail++; $display("FAIL stop_done: cycle %0d count %0d expected cycle 40 count 1", first_done, n_done); end
      n_tests++;
      if (scl_hist[40] !== 1'b0 || rdy_hist[40] !== 1'b1) begin n_fail++; $display("FAIL stop_idle: scl %b ready %b expected 0 1", scl_hist[40], rdy_hist[40]); end
   endtask

   task automatic test_illegal;
      issue(2'b01);
      observe(5);
      n_tests++;
      if (first_err !== 0 || n_err !== 1) begin n_fail++; $display("FAIL err_frame_idle: cycle %0d count %0d expected cycle 0 count 1", first_err, n_err); end
      n_tests++;
      if (n_done !== 0 || scl_hist[0] !== 1'b0 || scl_hist[4] !== 1'b0 || rdy_hist[4] !== 1'b1) begin
         n_fail++;
         $display("FAIL err_frame_idle_side: done %0d scl %b%b ready %b expected 0 00 1", n_done, scl_hist[0], scl_hist[4], rdy_hist[4]);
      end
      issue(2'b00);
      observe(21);
      issue(2'b11);
      observe(5);
      n_tests++;
      if (first_err !== 0 || n_err !== 1) begin n_fail++; $display("FAIL err_cmd11_hold: cycle %0d count %0d expected cycle 0 count 1", first_err, n_err); end
      n_tests++;
      if (n_done !== 0 || scl_hist[0] !== 1'b1 || scl_hist[4] !== 1'b1 || n_upd !== 0) begin
         n_fail++;
         $display("FAIL err_cmd11_side: done %0d scl %b%b upd %0d expected 0 11 0", n_done, scl_hist[0], scl_hist[4], n_upd);
      end
   endtask

   task automatic test_reset_mid;
      issue(2'b01);
      observe(170);
      n_tests++;
      if (bus.Bit_Index !== 4'd4 || bus.Scl_Oe !== 1'b1 || n_done !== 0) begin
         n_fail++;
         $display("FAIL midrst_before: idx %0d scl %b done %0d expected 4 1 0", bus.Bit_Index, bus.Scl_Oe, n_done);
      end
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_tests++;
      if (bus.Scl_Oe !== 1'b0 || bus.Bit_Index !== 4'd0) begin n_fail++; $display("FAIL midrst_after: scl %b idx %0d expected 0 0", bus.Scl_Oe, bus.Bit_Index); end
      n_tests++;
      if (bus.Done !== 1'b0 || bus.Cmd_Ready !== 1'b1) begin n_fail++; $display("FAIL midrst_state: done %b ready %b expected 0 1", bus.Done, bus.Cmd_Ready); end
      issue(2'b10);
      observe(4);
      n_tests++;
      if (n_err !== 1 || n_done !== 0 || scl_hist[3] !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_idle_check: err %0d done %0d scl %b expected 1 0 0", n_err, n_done, scl_hist[3]);
      end
   endtask

`ifdef SCL_STRETCH_EN
   task automatic test_stretch;
      int   c_smp, c_smp2, c_done, n_s, c_to, n_d;
      logic oe_mid, oe_to, rdy_to;
      issue(2'b00);
      observe(21);
      // The slave keeps SCL low from the start of the frame; pin released 50 cycles into
      // bit 0's high half, and the 2-flop synchroniser adds 2 more cycles of hold.
      bus.Scl_In = 1'b0;
      issue(2'b01);
      c_smp = -1; c_smp2 = -1; c_done = -1; n_s = 0; oe_mid = 1'b1;
      for (int c = 0; c < 420; c++) begin
         @(negedge clk);
         if (bus.Sda_Sample) begin
            if (n_s == 0) c_smp = c;
            if (n_s == 1) c_smp2 = c;
            n_s++;
         end
         if (bus.Done && c_done < 0) c_done = c;
         if (c == 50) oe_mid = bus.Scl_Oe;
         if (c == 70) bus.Scl_In = 1'b1;
      end
      n_tests++;
      if (c_smp !== 82 || c_smp2 !== 122) begin n_fail++; $display("FAIL stretch_sample: got %0d %0d expected 82 122", c_smp, c_smp2); end
      n_tests++;
      if (oe_mid !== 1'b0 || n_s !== BPF) begin n_fail++; $display("FAIL stretch_release: scl %b samples %0d expected 0 9", oe_mid, n_s); end
      n_tests++;
      if (c_done !== 412) begin n_fail++; $display("FAIL stretch_done: got %0d expected 412", c_done); end

      bus2.Cmd_Valid = 1'b1;
      bus2.Cmd = 2'b00;
      @(posedge clk);
      #1 bus2.Cmd_Valid = 1'b0;
      repeat (21) @(negedge clk);
      bus2.Scl_In = 1'b0;
      bus2.Cmd_Valid = 1'b1;
      bus2.Cmd = 2'b01;
      @(posedge clk);
      #1 bus2.Cmd_Valid = 1'b0;
      c_to = -1; n_d = 0; oe_to = 1'b1; rdy_to = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (bus2.Done) n_d++;
         if (bus2.Timeout && c_to < 0) begin
            c_to = c;
            oe_to = bus2.Scl_Oe;
            rdy_to = bus2.Cmd_Ready;
         end
      end
      n_tests++;
      if (c_to !== 50) begin n_fail++; $display("FAIL timeout_cycle: got %0d expected 50", c_to); end
      n_tests++;
      if (oe_to !== 1'b0 || rdy_to !== 1'b1 || n_d !== 0) begin
         n_fail++;
         $display("FAIL timeout_idle: scl %b ready %b done %0d expected 0 1 0", oe_to, rdy_to, n_d);
      end
      bus2.Scl_In = 1'b1;
   endtask
`endif

   initial begin
      test_reset();
      test_start();
      test_frame();
      test_rs_stop();
      test_illegal();
      test_reset_mid();
`ifdef SCL_STRETCH_EN
      test_stretch();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
